// File: rtl/seg7_scan_driver.sv
`timescale 1ns/1ps
// seg7_scan_driver: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. Software loads a 16-bit hex value and 4 dp bits;
// the block scans digits, decodes hex, optionally blanks leading zeros and
// swaps in new values only at frame boundaries so a frame never tears.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DIV_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        wr,
  input  logic [15:0] wdata,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [11:0] digi,
  output logic        frame_done
);

  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(SCAN_DIV - 1);

  logic [15:0]      shadow_val_q, shadow_val_d;
  logic [3:0]       shadow_dp_q,  shadow_dp_d;
  logic [15:0]      active_val_q, active_val_d;
  logic [3:0]       active_dp_q,  active_dp_d;
  logic             pending_q,    pending_d;
  logic [1:0]       idx_q,        idx_d;
  logic [DIV_W-1:0] cnt_q,        cnt_d;
  logic [11:0]      digi_q,       digi_d;
  logic             frame_done_q, frame_done_d;

  logic scan_last;
  logic frame_end;

  // Active-low segment pattern (g..a) for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // State registers, async active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      pending_q    <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
      digi_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      pending_q    <= pending_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      digi_q       <= digi_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Scan timing, shadow capture and frame-boundary swap of the active value.
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    pending_d    = pending_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;

    scan_last = (cnt_q == CNT_LAST);
    frame_end = scan_last && (idx_q == 2'd3);

    if (wr) begin
      shadow_val_d = wdata;
      shadow_dp_d  = dp_in;
    end

    if (!en) begin
      // Dark: nothing is on screen, so the new value can go straight through.
      // A write in this very cycle is forwarded so it is not lost if en rises next.
      cnt_d        = '0;
      idx_d        = '0;
      pending_d    = 1'b0;
      active_val_d = wr ? wdata : shadow_val_q;
      active_dp_d  = wr ? dp_in : shadow_dp_q;
    end else begin
      cnt_d        = scan_last ? '0 : cnt_q + DIV_W'(1);
      idx_d        = scan_last ? idx_q + 2'd1 : idx_q;
      frame_done_d = frame_end;
      if (frame_end && (pending_q || wr)) begin
        active_val_d = wr ? wdata : shadow_val_q;
        active_dp_d  = wr ? dp_in : shadow_dp_q;
        pending_d    = 1'b0;
      end else begin
        pending_d    = pending_q | wr;
      end
    end
  end

  // Pin word for the currently selected digit, with leading-zero blanking.
  always_comb begin
    logic [3:0] nib;
    logic       lz3, lz2, lz1;
    logic       blank;
    logic [3:0] anode;

    lz3 = (active_val_q[15:12] == 4'h0);
    lz2 = lz3 && (active_val_q[11:8] == 4'h0);
    lz1 = lz2 && (active_val_q[7:4] == 4'h0);

    case (idx_q)
      2'd0: begin nib = active_val_q[3:0];   blank = 1'b0; end
      2'd1: begin nib = active_val_q[7:4];   blank = lz1;  end
      2'd2: begin nib = active_val_q[11:8];  blank = lz2;  end
      default: begin nib = active_val_q[15:12]; blank = lz3; end
    endcase

    anode = ~(4'b0001 << idx_q);

    if (en) begin
      digi_d = {anode, ~active_dp_q[idx_q],
                (blank_lz && blank) ? 7'h7F : hex_to_seg(nib)};
    end else begin
      digi_d = '1;
    end
  end

  assign digi       = digi_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
`timescale 1ns/1ps
// Scoreboard bench for seg7_scan_driver: the driver predicts each cycle's
// pin word from a frame-level model and queues it; a negedge monitor checks.
module tb_seg7_scan_driver;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        wr;
  logic [15:0] wdata;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [11:0] digi;
  logic        frame_done;

  seg7_scan_driver #(.SCAN_DIV(SD), .DIV_W(3)) dut (
    .clk(clk), .reset(reset), .en(en), .wr(wr), .wdata(wdata),
    .dp_in(dp_in), .blank_lz(blank_lz), .digi(digi), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] digi;
    logic        fd;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state: what software wrote, what is on screen, and how
  // many cycles the display has been scanning since it was last enabled.
  logic [15:0] m_shadow, m_active;
  logic [3:0]  m_sdp, m_adp;
  bit          m_pend;
  int          m_t;

  function automatic logic [11:0] render(int k, logic [15:0] v, logic [3:0] dp, logic blz);
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] upper;
    upper = v >> (4 * k);
    if (blz && k > 0 && upper == 16'h0) seg = 7'h7F;
    else seg = HEX[upper[3:0]];
    an = 4'hF;
    an[k] = 1'b0;
    return {an, ~dp[k], seg};
  endfunction

  task automatic model_reset();
    m_shadow = '0; m_active = '0; m_sdp = '0; m_adp = '0;
    m_pend = 0; m_t = 0;
  endtask

  task automatic check(string name, logic [11:0] act, logic [11:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; prediction is pushed once the edge has happened.
  task automatic step(input logic i_en, input logic i_wr, input logic [15:0] i_wd,
                      input logic [3:0] i_dp, input logic i_blz);
    exp_t e;
    en = i_en; wr = i_wr; wdata = i_wd; dp_in = i_dp; blank_lz = i_blz;
    if (i_en) begin
      int  k;
      bit  bnd;
      k   = (m_t / SD) % 4;
      bnd = (m_t % (4 * SD)) == (4 * SD - 1);
      e.digi = render(k, m_active, m_adp, i_blz);
      e.fd   = bnd;
      if (bnd && (m_pend || i_wr)) begin
        m_active = i_wr ? i_wd : m_shadow;
        m_adp    = i_wr ? i_dp : m_sdp;
        m_pend   = 0;
      end else begin
        m_pend = m_pend || i_wr;
      end
      m_t++;
    end else begin
      e.digi   = 12'hFFF;
      e.fd     = 1'b0;
      m_active = i_wr ? i_wd : m_shadow;
      m_adp    = i_wr ? i_dp : m_sdp;
      m_pend   = 0;
      m_t      = 0;
    end
    if (i_wr) begin
      m_shadow = i_wd;
      m_sdp    = i_dp;
    end
    @(posedge clk);
    cyc++;
    e.cyc = cyc;
    exp_q.push_back(e);
    #1;
    wr = 1'b0;
  endtask

  task automatic idle(int n, logic i_en, logic i_blz);
    for (int i = 0; i < n; i++) step(i_en, 1'b0, 16'h0, 4'h0, i_blz);
  endtask

  // Monitor: compare each predicted cycle away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++;
      if (digi !== e.digi) begin
        fails++;
        $display("FAIL digi cyc %0d: got %h, expected %h", e.cyc, digi, e.digi);
      end
      tests++;
      if (frame_done !== e.fd) begin
        fails++;
        $display("FAIL frame_done cyc %0d: got %b, expected %b", e.cyc, frame_done, e.fd);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic cur_en, cur_blz;
    reset = 1'b1; en = 1'b0; wr = 1'b0; wdata = '0; dp_in = '0; blank_lz = 1'b0;
    model_reset();
    #3;
    check("reset_digi", digi, 12'hFFF);
    check("reset_fd", {11'h0, frame_done}, 12'h000);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Value 0, plain scan across several frames.
    idle(40, 1'b1, 1'b0);

    // Mid-frame load during digit 1.
    while (((m_t / SD) % 4) != 1) idle(1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'h1234, 4'b0010, 1'b0);
    idle(40, 1'b1, 1'b0);

    // Leading-zero blanking.
    step(1'b1, 1'b1, 16'h00A0, 4'h0, 1'b1);
    idle(36, 1'b1, 1'b1);
    step(1'b1, 1'b1, 16'h0000, 4'h0, 1'b1);
    idle(36, 1'b1, 1'b1);

    // Load landing exactly on the frame boundary.
    while ((m_t % (4 * SD)) != (4 * SD - 1)) idle(1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'hFFFF, 4'h0, 1'b0);
    idle(40, 1'b1, 1'b0);

    // Disable mid-scan, write while dark, re-enable.
    idle(6, 1'b1, 1'b0);
    idle(3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h5678, 4'h0, 1'b0);
    idle(2, 1'b0, 1'b0);
    idle(20, 1'b1, 1'b0);

    // Write then enable on the very next cycle.
    step(1'b0, 1'b1, 16'h9ABC, 4'b0101, 1'b0);
    idle(20, 1'b1, 1'b0);

    // Async reset mid-digit with a pending load.
    idle(2, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'h4321, 4'hF, 1'b0);
    idle(1, 1'b1, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("async_reset_digi", digi, 12'hFFF);
    check("async_reset_fd", {11'h0, frame_done}, 12'h000);
    model_reset();
    #2;
    reset = 1'b0;
    idle(40, 1'b1, 1'b0);

    // Randomized traffic.
    cur_en = 1'b1; cur_blz = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] mask, d;
      logic        w;
      if ($urandom_range(0, 29) == 0) cur_en = ~cur_en;
      if ($urandom_range(0, 49) == 0) cur_blz = ~cur_blz;
      case ($urandom_range(0, 3))
        0: mask = 16'hFFFF;
        1: mask = 16'h00FF;
        2: mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      d = 16'($urandom) & mask;
      w = ($urandom_range(0, 7) == 0);
      step(cur_en, w, d, 4'($urandom), cur_blz);
    end

    @(posedge clk); @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
